// File: rtl/jpeg_fdct_pkg.sv
// Shared constants for the 8x8 forward DCT: cosine ROM, zigzag map, pass shifts and FSM states.
package jpeg_fdct_pkg;

    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} fdct_state_e;

    localparam int ROM_W     = 13;
    localparam int ROW_SHIFT = 10;
    localparam int COL_SHIFT = 14;

    // C[k][n] = round(4096 * c(k)/2 * cos((2n+1)k*pi/16))
    localparam int COS_ROM [8][8] = '{
        '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
        '{2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
        '{1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
        '{1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
        '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
        '{1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
        '{ 784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
        '{ 400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
    };

    localparam int ZZ_TO_RASTER [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/jpeg_fdct_mac.sv
// Shared multiply-accumulate for both DCT passes: one tap per cycle, round/shift and
// optional saturation applied on the registered sum when the last tap has landed.
module jpeg_fdct_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 13,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int SAT_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     issue,
    input  logic                     clr,
    input  logic                     last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    input  logic [4:0]               shift,
    input  logic                     sat_en,
    output logic signed [OUT_W-1:0]  res,
    output logic                     res_vld
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (SAT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (SAT_W - 1)));

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                            input logic [4:0] s);
        logic signed [ACC_W-1:0] bias;
        bias = ACC_W'(1) <<< (s - 5'd1);
        return (v + bias) >>> s;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return OUT_W'(SAT_MAX);
        if (v < SAT_MIN) return OUT_W'(SAT_MIN);
        return OUT_W'(v);
    endfunction

    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_p0;
    logic signed [ACC_W-1:0] rnd;
    logic                    vld_p0;

    assign prod = ACC_W'(a) * ACC_W'(b);

    // p0: accumulator, restarted by the first tap of each output
    always_ff @(posedge clk) begin
        if (issue) acc_p0 <= clr ? prod : acc_p0 + prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= issue & last & ~flush;
    end

    assign rnd     = round_shift(acc_p0, shift);
    assign res     = sat_en ? sat(rnd) : OUT_W'(rnd);
    assign res_vld = vld_p0;

endmodule

// File: rtl/jpeg_fdct.sv
// Forward 8x8 DCT (row pass then column pass) on one time-shared MAC, single-buffered.
// Define JPEG_FDCT_ZIGZAG_EN to emit coefficients in JPEG zigzag order instead of raster.
module jpeg_fdct
    import jpeg_fdct_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = ROM_W,
    parameter int TMP_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              img_start_i,
    input  logic              inport_valid_i,
    input  logic [DATA_W-1:0] inport_data_i,
    input  logic [5:0]        inport_idx_i,
    input  logic [31:0]       inport_id_i,
    output logic              inport_accept_o,
    output logic              outport_valid_o,
    output logic [15:0]       outport_data_o,
    output logic [5:0]        outport_idx_o,
    output logic [31:0]       outport_id_o,
    input  logic              outport_accept_i
);

    localparam int PIX_W = DATA_W + 1;
    localparam int SAT_W = 12;

    fdct_state_e state, state_nxt;
    logic [9:0]  cnt;
    logic [6:0]  ocnt;
    logic [31:0] blk_id;
    logic [5:0]  waddr_p0;
    logic [5:0]  rd_addr;
    logic        in_fire, last_pix, pass_done, out_done, issue;

    logic signed [PIX_W-1:0]  pix  [64];
    logic signed [TMP_W-1:0]  tmem [64];
    logic signed [SAT_W-1:0]  fmem [64];

    logic signed [TMP_W-1:0]  mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [TMP_W-1:0]  mac_res;
    logic                     mac_vld;
    logic [4:0]               mac_shift;

    assign in_fire   = inport_valid_i & inport_accept_o & ~img_start_i;
    assign last_pix  = in_fire & (cnt[5:0] == 6'd63);
    assign pass_done = (cnt == 10'd512);
    assign out_done  = outport_valid_o & outport_accept_i & ocnt[6];
    assign issue     = ((state == ROW) || (state == COL)) & ~cnt[9];

    always_comb begin
        state_nxt = state;
        if (img_start_i) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (last_pix)  state_nxt = ROW;
                ROW:     if (pass_done) state_nxt = COL;
                COL:     if (pass_done) state_nxt = OUT;
                OUT:     if (out_done)  state_nxt = LOAD;
                default:                state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= LOAD;
            cnt             <= '0;
            blk_id          <= '0;
            inport_accept_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            inport_accept_o <= (state_nxt == LOAD);
            // cnt counts accepted pixels in LOAD and MAC taps (plus drain) in ROW/COL
            if (img_start_i || (state_nxt != state)) cnt <= '0;
            else if (in_fire || (state == ROW) || (state == COL)) cnt <= cnt + 10'd1;
            if (last_pix) blk_id <= inport_id_i;
        end
    end

    // Tap order: ROW cnt={r,k,n} reads pix[r][n]; COL cnt={k,c,n} reads T[n][c]
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state == COL) begin
            mac_a = tmem[{cnt[2:0], cnt[5:3]}];
            mac_b = COEF_W'(COS_ROM[cnt[8:6]][cnt[2:0]]);
        end else begin
            mac_a = TMP_W'(pix[{cnt[8:6], cnt[2:0]}]);
            mac_b = COEF_W'(COS_ROM[cnt[5:3]][cnt[2:0]]);
        end
    end

    assign mac_shift = (state == COL) ? 5'(COL_SHIFT) : 5'(ROW_SHIFT);

    jpeg_fdct_mac #(
        .DATA_W (TMP_W),
        .COEF_W (COEF_W),
        .ACC_W  (32),
        .OUT_W  (TMP_W),
        .SAT_W  (SAT_W)
    ) u_mac (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .flush   (img_start_i),
        .issue   (issue),
        .clr     (cnt[2:0] == 3'd0),
        .last    (cnt[2:0] == 3'd7),
        .a       (mac_a),
        .b       (mac_b),
        .shift   (mac_shift),
        .sat_en  (state == COL),
        .res     (mac_res),
        .res_vld (mac_vld)
    );

    // p0: write-back address travels with the MAC accumulator
    always_ff @(posedge clk_i) begin
        if (issue) waddr_p0 <= cnt[8:3];
        if (in_fire) pix[inport_idx_i] <= $signed({1'b0, inport_data_i}) - PIX_W'(128);
        if (mac_vld && (state == ROW)) tmem[waddr_p0] <= mac_res;
        if (mac_vld && (state == COL)) fmem[waddr_p0] <= mac_res[SAT_W-1:0];
    end

`ifdef JPEG_FDCT_ZIGZAG_EN
    assign rd_addr = 6'(ZZ_TO_RASTER[ocnt[5:0]]);
`else
    assign rd_addr = ocnt[5:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            outport_valid_o <= 1'b0;
            outport_data_o  <= '0;
            outport_idx_o   <= '0;
            outport_id_o    <= '0;
            ocnt            <= '0;
        end else if (img_start_i) begin
            outport_valid_o <= 1'b0;
            ocnt            <= '0;
        end else if ((state == OUT) && (!outport_valid_o || outport_accept_i)) begin
            if (!ocnt[6]) begin
                outport_valid_o <= 1'b1;
                outport_data_o  <= 16'(fmem[rd_addr]);
                outport_idx_o   <= ocnt[5:0];
                outport_id_o    <= blk_id;
                ocnt            <= ocnt + 7'd1;
            end else begin
                outport_valid_o <= 1'b0;
                ocnt            <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_fdct.sv
// Directed bench for jpeg_fdct: flat blocks, single-pixel impulse, random blocks with stalls, flush and reset.
module tb_jpeg_fdct;

    logic        clk = 1'b0;
    logic        rst_i, img_start_i, inport_valid_i, inport_accept_o;
    logic [7:0]  inport_data_i;
    logic [5:0]  inport_idx_i;
    logic [31:0] inport_id_i;
    logic        outport_valid_o, outport_accept_i;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic [31:0] outport_id_o;

    int n_cmp = 0;
    int n_err = 0;
    int rom  [8][8];
    int pixv [64];
    int expv [64];
    int gotv [64];

`ifdef JPEG_FDCT_ZIGZAG_EN
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    function automatic int pos(input int j); return ZZ[j]; endfunction
`else
    function automatic int pos(input int j); return j; endfunction
`endif

    always #5 clk = ~clk;

    jpeg_fdct dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .img_start_i      (img_start_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_idx_i     (inport_idx_i),
        .inport_id_i      (inport_id_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_idx_o    (outport_idx_o),
        .outport_id_o     (outport_id_o),
        .outport_accept_i (outport_accept_i)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model();
        int t [64];
        longint s;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                s = 0;
                for (int n = 0; n < 8; n++) s += longint'((pixv[r*8+n] - 128) * rom[k][n]);
                t[r*8+k] = int'((s + 512) >>> 10);
            end
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int n = 0; n < 8; n++) s += longint'(t[n*8+c] * rom[k][n]);
                s = (s + 8192) >>> 14;
                if (s > 2047) s = 2047;
                if (s < -2048) s = -2048;
                expv[k*8+c] = int'(s);
            end
    endfunction

    function automatic void flat(input int v, input int f0);
        for (int i = 0; i < 64; i++) begin
            pixv[i] = v;
            expv[i] = 0;
        end
        expv[0] = f0;
    endfunction

    task automatic send_block(input logic [31:0] id);
        int guard, stuck;
        stuck = 0;
        for (int i = 0; i < 64; i++) begin
            inport_valid_i = 1'b1;
            inport_data_i  = 8'(pixv[i]);
            inport_idx_i   = 6'(i);
            inport_id_i    = id;
            guard = 0;
            @(negedge clk);
            while (!inport_accept_o && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 3000) stuck++;
            @(posedge clk); #1;
        end
        inport_valid_i = 1'b0;
        chk("send_timeout", stuck, 0);
    endtask

    task automatic wait_latency(input int exp_lat);
        int n;
        n = 0;
        while (!outport_valid_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_lat);
    endtask

    task automatic recv_block(input bit stall, input logic [31:0] exp_id);
        int taken, guard;
        logic pv, pa;
        logic [15:0] pd;
        logic [5:0] pi;
        logic [31:0] pid;
        taken = 0; guard = 0; pv = 1'b0; pa = 1'b1; pd = '0; pi = '0; pid = '0;
        while (taken < 64 && guard < 5000) begin
            outport_accept_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pv && !pa) begin
                chk("stall_valid", 32'(outport_valid_o), 1);
                chk("stall_data", 32'(outport_data_o), 32'(pd));
                chk("stall_idx", 32'(outport_idx_o), 32'(pi));
                chk("stall_id", outport_id_o, pid);
            end
            if (outport_valid_o && outport_accept_i) begin
                gotv[pos(taken)] = 32'($signed(outport_data_o));
                chk("out_idx", 32'(outport_idx_o), taken);
                chk("out_data", 32'($signed(outport_data_o)), expv[pos(taken)]);
                chk("out_id", outport_id_o, exp_id);
                taken++;
            end
            pv = outport_valid_o; pa = outport_accept_i;
            pd = outport_data_o; pi = outport_idx_o; pid = outport_id_o;
            @(posedge clk); #1;
            guard++;
        end
        outport_accept_i = 1'b0;
        chk("recv_count", taken, 64);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(outport_valid_o), 0);
        chk({tag, "_data"}, 32'(outport_data_o), 0);
        chk({tag, "_idx"}, 32'(outport_idx_o), 0);
        chk({tag, "_id"}, outport_id_o, 0);
        chk({tag, "_accept"}, 32'(inport_accept_o), 0);
    endtask

    initial begin
        int seen;
        rst_i = 1'b0; img_start_i = 1'b0; inport_valid_i = 1'b0;
        inport_data_i = '0; inport_idx_i = '0; inport_id_i = '0; outport_accept_i = 1'b0;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                rom[k][n] = int'(4096.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) / 2.0 *
                                 $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0));

        repeat (3) @(posedge clk); #1;
        chk_zero_outputs("reset");
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("accept_after_reset", 32'(inport_accept_o), 1);

        // mid-grey block: everything cancels
        flat(128, 0);
        send_block(32'h1);
        wait_latency(1027);
        recv_block(1'b0, 32'h1);

        // full white and full black: DC only
        flat(255, 1016);
        send_block(32'h2);
        wait_latency(1027);
        recv_block(1'b0, 32'h2);
        flat(0, -1024);
        send_block(32'h3);
        recv_block(1'b0, 32'h3);

        // single bright pixel at the origin
        flat(128, 0);
        pixv[0] = 255;
        model();
        send_block(32'h4);
        recv_block(1'b0, 32'h4);
        chk("impulse_dc", gotv[0], 16);

        // random content, back-to-back, random downstream stalls
        for (int i = 0; i < 64; i++) pixv[i] = int'($urandom_range(0, 255));
        model();
        send_block(32'hA5A5_0001);
        recv_block(1'b1, 32'hA5A5_0001);
        for (int i = 0; i < 64; i++) pixv[i] = int'($urandom_range(0, 255));
        model();
        send_block(32'hA5A5_0002);
        recv_block(1'b1, 32'hA5A5_0002);

        // flush while the column pass is running
        for (int i = 0; i < 64; i++) pixv[i] = int'($urandom_range(0, 255));
        send_block(32'h5);
        repeat (700) @(posedge clk); #1;
        img_start_i = 1'b1;
        @(posedge clk); #1;
        img_start_i = 1'b0;
        chk("flush_valid", 32'(outport_valid_o), 0);
        chk("flush_accept", 32'(inport_accept_o), 1);
        seen = 0;
        repeat (1100) begin
            @(posedge clk); #1;
            if (outport_valid_o) seen++;
        end
        chk("flush_no_output", seen, 0);
        flat(255, 1016);
        send_block(32'h6);
        wait_latency(1027);
        recv_block(1'b0, 32'h6);

        // reset while coefficients are being emitted
        flat(0, -1024);
        send_block(32'h7);
        wait_latency(1027);
        outport_accept_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chk_zero_outputs("midout_reset");
        outport_accept_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("accept_after_midout_reset", 32'(inport_accept_o), 1);
        flat(255, 1016);
        send_block(32'h8);
        wait_latency(1027);
        recv_block(1'b1, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_fdct.md
Name: jpeg_fdct

Overview:
- Forward 8x8 DCT for the JPEG encoder path.
- Accepts 64 unsigned 8-bit pixel samples per block, level-shifts them, and runs a two-pass (row, then column) separable DCT on one time-multiplexed MAC.
- Emits 64 signed coefficients with index and block ID.
- Sits between the colour/block-split front end and the quantiser.

Parameters:
- COEF_W, 13: signed cosine ROM width, scale 2^12.
- TMP_W, 16: signed row-pass intermediate width (2 fractional bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- img_start_i  in  1  flush: abort current block, return to LOAD
- inport_valid_i  in  1  pixel valid
- inport_data_i  in  8  unsigned pixel
- inport_idx_i  in  6  raster position (row*8+col)
- inport_id_i  in  32  block ID, sampled on 64th accept
- inport_accept_o  out  1  pixel accepted this cycle when valid&accept
- outport_valid_o  out  1  coefficient valid
- outport_data_o  out  16  signed coefficient, sign-extended from 12 bits
- outport_idx_o  out  6  coefficient position
- outport_id_o  out  32  ID of block being output
- outport_accept_i  in  1  downstream takes coefficient when valid&accept

Behaviour:
- Reset values: all outputs 0, state LOAD, counters 0. inport_accept_o rises the first cycle after reset deasserts.
- States:
  - LOAD: inport_accept_o=1. Each accept writes (data-128) as 9-bit signed into pix[idx] and increments cnt. Duplicate idx overwrites but still counts. On the 64th accept, capture ID and go to ROW.
  - ROW: for r,k in 0..7, T[r][k] = round(sum_n pix[r][n]*C[k][n] >> 10). One tap/cycle, 512 issue cycles + 1 drain, then COL.
  - COL: for k,c in 0..7, F[k][c] = sat12(round(sum_n T[n][c]*C[k][n] >> 14)). 513 cycles, then OUT.
  - OUT: present F in index order 0..63. Advance only on valid&accept. After idx 63 is taken, go to LOAD.
- Cosine ROM: C[k][n] = round(4096*c(k)/2*cos((2n+1)kπ/16)), with c(0)=1/√2 and c(k)=1 otherwise; C[0][n]=1448.
- Rounding: add 2^(s-1), then arithmetic shift right by s. sat12 clamps to [-2048,2047].
- Accumulator: 32-bit signed; no overflow is reachable.
- Latency: outport_valid_o first asserts on the 1027th rising edge after the edge accepting sample 64.
- inport_accept_o=0 in ROW/COL/OUT. The block is single-buffered and does not overlap LOAD with OUT.
- Output holds data/idx/id stable while valid&!accept.
- img_start_i (synchronous, any state): discard pix/T/F, cnt=0, outport_valid_o=0 next cycle, state LOAD. Takes priority over a same-cycle accept.
- Reset mid-operation: immediate return to reset values; any partial block is lost.

Optional Feature:
- JPEG_FDCT_ZIGZAG_EN.
- Defined: OUT emits coefficients in JPEG zigzag order, and outport_idx_o carries the zigzag index (0..63). The sequence is F[0][0], F[0][1], F[1][0], F[2][0], ...
- Undefined: raster order, outport_idx_o = k*8+c.

Decomposition:
- Package jpeg_fdct_pkg:
  - cosine ROM constant array (8x8 x COEF_W)
  - zigzag-to-raster 64x6 table
  - state enum {LOAD,ROW,COL,OUT}
  - ROW_SHIFT=10, COL_SHIFT=14
- Sub-module jpeg_fdct_mac: registered multiply-accumulate with clear, round/shift, and optional saturate. It is shared by both passes.

Test Plan:
- 64 pixels all 128 -> all 64 coefficients 0; first valid 1027 edges after last accept.
- All 255 -> F[0]=1016, others 0.
- All 0 -> F[0]=-1024, others 0.
- Pixel idx0=255, rest 128 -> F[0]=16; all 64 values match the bit-exact integer model using the same ROM and rounding.
- Random pixels, outport_accept_i toggled 50% random -> data/idx/id stable while stalled. Two back-to-back blocks carry IDs 0xA5A5_0001 and 0xA5A5_0002.
- img_start_i asserted mid-COL, and rst_i pulsed low mid-OUT -> outputs reset/flush as specified. The next block of all 255 yields F[0]=1016 with no residue from the aborted block.
